dmem_responder: RTL

// - Target end of the CPU's MEM-stage data interface: services one load/store at a time into a word-addressed RAM.
// - Fixed, parameterised latency; holds the pipeline with stall until the access completes.
// - Sits beside MEM_slice: MEM_slice drives re/we/addr/wdata and consumes rdata/stall.
// - stall feeds the shared pipeline stall net.

---
 rtl/dmem_if.sv | 21 ++
 rtl/dmem_responder.sv | 129 ++++++++++++
 2 files changed

// File: rtl/dmem_if.sv
// MEM-stage data bus between the CPU (master) and dmem_responder (slave).
// The err signal exists only when DMEM_ERR_EN is defined.
interface dmem_if #(
  parameter int DATA_W = 16
);
  logic              re;
  logic              we;
  logic [15:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              stall;
`ifdef DMEM_ERR_EN
  logic              err;

  modport master (output re, we, addr, wdata, input rdata, stall, err);
  modport slave  (input re, we, addr, wdata, output rdata, stall, err);
`else
  modport master (output re, we, addr, wdata, input rdata, stall);
  modport slave  (input re, we, addr, wdata, output rdata, stall);
`endif
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency, single-outstanding load/store responder for a word-addressed RAM.
// Optional feature macro: DMEM_ERR_EN (flags and suppresses out-of-range accesses).
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting; a request stalls combinationally and is latched
// BUSY   | access in flight, cnt counts down to the commit edge
// DONE   | one stall-free cycle so the CPU advances; inputs ignored
module dmem_responder #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              re_q;
  logic              we_q;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              req;
  logic              accept;
  logic              commit;
  logic              cur_re;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_idx;
  logic [DATA_W-1:0] cur_wdata;
  logic              cur_bad;

  assign req    = bus.re | bus.we;
  assign accept = rst && (state == S_IDLE) && req;
  // With LATENCY=1 the request cycle is also the last stall cycle, so live inputs commit.
  assign commit = (accept && (LATENCY == 1)) || (rst && (state == S_BUSY) && (cnt == 4'd1));

  assign cur_re    = (state == S_IDLE) ? bus.re                 : re_q;
  assign cur_we    = (state == S_IDLE) ? bus.we                 : we_q;
  assign cur_idx   = (state == S_IDLE) ? bus.addr[ADDR_W-1:0]   : idx_q;
  assign cur_wdata = (state == S_IDLE) ? bus.wdata              : wdata_q;

`ifdef DMEM_ERR_EN
  logic hi_q;
  logic cur_hi;

  assign cur_hi  = (state == S_IDLE) ? (|bus.addr[15:ADDR_W]) : hi_q;
  assign cur_bad = cur_hi;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q    <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      if (accept) begin
        hi_q    <= |bus.addr[15:ADDR_W];
        bus.err <= 1'b0;
      end
      if (commit) begin
        bus.err <= cur_bad;
      end
    end
  end
`else
  assign cur_bad = 1'b0;
`endif

  assign bus.stall = rst && (((state == S_IDLE) && req) || (state == S_BUSY));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            re_q    <= bus.re;
            we_q    <= bus.we;
            idx_q   <= bus.addr[ADDR_W-1:0];
            wdata_q <= bus.wdata;
            cnt     <= CNT_INIT;
            state   <= (LATENCY == 1) ? S_DONE : S_BUSY;
          end
        end
        S_BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read and write share the commit edge; the nonblocking read returns the old word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rdata <= '0;
    end else if (commit && cur_re) begin
      bus.rdata <= cur_bad ? '0 : mem[cur_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (commit && cur_we && !cur_bad) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

endmodule
